// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and multi-cycle mul/div stalls.
// Optional stall/flush statistics counters are enabled with the HAZARD_STATS_EN macro.
module hazard_ctrl #(
   parameter int unsigned MD_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rt,
   input  logic       EX_branchTaken,
   input  logic       EX_mdStart,
   output logic       PC_write,
   output logic       IF_ID_enable,
   output logic       IF_ID_flush,
   output logic       ID_EX_flush,
`ifdef HAZARD_STATS_EN
   output logic       busy,
   output logic [15:0] stallCount,
   output logic [15:0] flushCount
`else
   output logic       busy
`endif
);

   typedef enum logic {RUN, MD_BUSY} state_t;

   state_t     state_q, state_d;
   logic [7:0] md_cnt_q, md_cnt_d;
   logic       load_use;

   assign load_use = EX_MemRead && (EX_rt != 5'd0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));

   always_comb begin
      PC_write     = 1'b1;
      IF_ID_enable = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      busy         = 1'b0;
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      // Reset is folded in so the outputs read "free-running" while rst is held low.
      if (rst) begin
         case (state_q)
            RUN: begin
               if (EX_branchTaken) begin
                  IF_ID_flush = 1'b1;
                  ID_EX_flush = 1'b1;
               end else if (EX_mdStart) begin
                  PC_write     = 1'b0;
                  IF_ID_enable = 1'b0;
                  state_d      = MD_BUSY;
                  md_cnt_d     = 8'(MD_CYCLES - 1);
               end else if (load_use) begin
                  PC_write     = 1'b0;
                  IF_ID_enable = 1'b0;
                  ID_EX_flush  = 1'b1;
               end
            end
            MD_BUSY: begin
               PC_write     = 1'b0;
               IF_ID_enable = 1'b0;
               busy         = 1'b1;
               // Counter parks at 1 on exit so it never reaches 0 after reset.
               if (md_cnt_q <= 8'd1) state_d = RUN;
               else                  md_cnt_d = md_cnt_q - 8'd1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         md_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_count_q, stall_count_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (!PC_write && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
      if (IF_ID_flush && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count_q <= 16'd0;
         flush_count_q <= 16'd0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stallCount = stall_count_q;
   assign flushCount = flush_count_q;
`endif

endmodule
